seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_if.sv | 20 ++
 rtl/seg_display_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_if.sv
// Value-transfer and display-drive bundle for seg_display_ctrl.
// The producer side holds the master modport; the controller holds the slave modport.
interface seg_display_if;
    logic       in_valid;
    logic [7:0] in_num;
    logic       in_ready;
    logic       done;
    logic [3:0] an;
    logic [3:0] seg_code;

    modport master (
        output in_valid, in_num,
        input  in_ready, done, an, seg_code
    );

    modport slave (
        input  in_valid, in_num,
        output in_ready, done, an, seg_code
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Signed 8-bit to 4-digit multiplexed display driver using a shift-add-3 binary-to-BCD conversion.
// Optional macro BLANK_LEADING_ZEROS_EN shows leading zero hundreds/tens as blank (code 14).
module seg_display_ctrl #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_display_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

    localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);
    localparam logic [3:0]  CODE_BLANK  = 4'd14;
    localparam logic [3:0]  CODE_MINUS  = 4'd15;

    // Assert asynchronously, release two edges later so every flop leaves reset cleanly.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [7:0]  abs_q, abs_d;
    logic [3:0]  hun_q, hun_d, ten_q, ten_d, one_q, one_d;
    logic        disp_sign_q, disp_sign_d;
    logic [3:0]  disp_hun_q, disp_hun_d, disp_ten_q, disp_ten_d, disp_one_q, disp_one_d;
    logic        in_ready_q, in_ready_d;
    logic        done_q, done_d;
    logic [15:0] refresh_q, refresh_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  seg_q, seg_d;

    logic        transfer;
    logic [7:0]  in_abs;
    logic [19:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [3:0] digit_code(
        input logic [1:0] idx,
        input logic       sgn,
        input logic [3:0] hun,
        input logic [3:0] ten,
        input logic [3:0] one
    );
        logic [3:0] code;
        case (idx)
            2'd0:    code = one;
`ifdef BLANK_LEADING_ZEROS_EN
            2'd1:    code = (hun == 4'd0 && ten == 4'd0) ? CODE_BLANK : ten;
            2'd2:    code = (hun == 4'd0) ? CODE_BLANK : hun;
`else
            2'd1:    code = ten;
            2'd2:    code = hun;
`endif
            default: code = sgn ? CODE_MINUS : CODE_BLANK;
        endcase
        return code;
    endfunction

    assign transfer = bus.in_valid && in_ready_q;
    assign in_abs   = bus.in_num[7] ? (~bus.in_num + 8'd1) : bus.in_num;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        abs_d       = abs_q;
        hun_d       = hun_q;
        ten_d       = ten_q;
        one_d       = one_q;
        disp_sign_d = disp_sign_q;
        disp_hun_d  = disp_hun_q;
        disp_ten_d  = disp_ten_q;
        disp_one_d  = disp_one_q;
        shifted     = {add3(hun_q), add3(ten_q), add3(one_q), abs_q} << 1;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    sign_d  = bus.in_num[7];
                    abs_d   = in_abs;
                    hun_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // The abs MSB shifts into one[0]; column carries ripple upward through the shift.
                {hun_d, ten_d, one_d, abs_d} = shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: begin
                disp_sign_d = sign_q;
                disp_hun_d  = hun_q;
                disp_ten_d  = ten_q;
                disp_one_d  = one_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered decodes of the current state.
        done_d     = (state_q == COMMIT);
        in_ready_d = (state_q == IDLE) && !transfer;

        if (refresh_q == REFRESH_MAX) begin
            refresh_d = 16'd0;
            idx_d     = idx_q + 2'd1;
        end else begin
            refresh_d = refresh_q + 16'd1;
            idx_d     = idx_q;
        end

        an_d  = ~(4'b0001 << idx_d);
        seg_d = digit_code(idx_d, disp_sign_d, disp_hun_d, disp_ten_d, disp_one_d);
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            sign_q      <= 1'b0;
            abs_q       <= 8'd0;
            hun_q       <= 4'd0;
            ten_q       <= 4'd0;
            one_q       <= 4'd0;
            disp_sign_q <= 1'b0;
            disp_hun_q  <= 4'd0;
            disp_ten_q  <= 4'd0;
            disp_one_q  <= 4'd0;
            in_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            refresh_q   <= 16'd0;
            idx_q       <= 2'd0;
            an_q        <= 4'b1110;
            seg_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            abs_q       <= abs_d;
            hun_q       <= hun_d;
            ten_q       <= ten_d;
            one_q       <= one_d;
            disp_sign_q <= disp_sign_d;
            disp_hun_q  <= disp_hun_d;
            disp_ten_q  <= disp_ten_d;
            disp_one_q  <= disp_one_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            refresh_q   <= refresh_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign bus.an       = an_q;
    assign bus.seg_code = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl with a short refresh period.
// Expected leading-digit codes follow BLANK_LEADING_ZEROS_EN when it is defined.
module tb_seg_display_ctrl;

`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [3:0] LEAD = 4'd14;
`else
    localparam logic [3:0] LEAD = 4'd0;
`endif

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    seg_display_if bus();

    seg_display_ctrl #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the given digit is enabled, then sample its code.
    task automatic read_code(input int idx, output logic [3:0] code);
        logic [3:0] want;
        int w;
        want = ~(4'b0001 << idx);
        w = 0;
        @(negedge clk);
        while (bus.an !== want && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("an_wait", (w < 64), 1);
        code = bus.seg_code;
    endtask

    task automatic check_disp(input string tag, input logic [3:0] e3, input logic [3:0] e2,
                              input logic [3:0] e1, input logic [3:0] e0);
        logic [3:0] c;
        read_code(0, c); check({tag, "_one"},  c, e0);
        read_code(1, c); check({tag, "_ten"},  c, e1);
        read_code(2, c); check({tag, "_hun"},  c, e2);
        read_code(3, c); check({tag, "_sign"}, c, e3);
    endtask

    // One transfer; lat = edges after the transfer edge until done, rdy_k = edges until in_ready returns.
    task automatic send(input logic [7:0] v, output int lat, output int rdy_k, output int done_cnt);
        int w;
        w = 0; lat = -1; rdy_k = -1; done_cnt = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_num   = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (bus.in_ready === 1'b1) begin
                rdy_k = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, rdy_k, dcnt, w, low_cnt, high_cnt, first_high;
        int done_k [2];
        logic [3:0] pat [4];

        bus.in_valid = 1'b0;
        bus.in_num   = 8'd0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_done",     bus.done, 0);
        check("rst_an",       bus.an, 4'b1110);
        check("rst_seg",      bus.seg_code, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_done",     bus.done, 0);

        // Digit scan: each enable held exactly 4 cycles.
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        w = 0;
        while (bus.an !== 4'b0111 && w < 40) begin @(negedge clk); w++; end
        while (bus.an === 4'b0111 && w < 40) begin @(negedge clk); w++; end
        check("scan_align", (w < 40), 1);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                check("scan_an", bus.an, pat[s]);
                @(negedge clk);
            end
        end
        check("scan_wrap", bus.an, 4'b1110);

        send(8'd123, lat, rdy_k, dcnt);
        check("v123_latency", lat, 9);
        check("v123_ready_back", rdy_k, 10);
        check("v123_done_width", dcnt, 1);
        check_disp("v123", 4'd14, 4'd1, 4'd2, 4'd3);

        send(8'h80, lat, rdy_k, dcnt);
        check("m128_latency", lat, 9);
        check_disp("m128", 4'd15, 4'd1, 4'd2, 4'd8);

        send(8'd7, lat, rdy_k, dcnt);
        check("v7_latency", lat, 9);
        check_disp("v7", 4'd14, LEAD, LEAD, 4'd7);

        // Back-to-back: valid stays high, value changes right after the first transfer.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_num   = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_num = 8'd9;
        done_k = '{-1, -1};
        dcnt = 0; low_cnt = 0; high_cnt = 0; first_high = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) begin
                if (dcnt < 2) done_k[dcnt] = k;
                dcnt++;
            end
            if (bus.in_ready === 1'b0) low_cnt++;
            if (bus.in_ready === 1'b1) begin
                high_cnt++;
                if (first_high < 0) first_high = k;
                if (high_cnt == 2) begin
                    bus.in_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_done1", done_k[0], 9);
        check("b2b_ready_after_done", first_high, 10);
        check("b2b_done2", done_k[1], 20);
        check("b2b_ready_low", low_cnt, 20);
        check_disp("b2b", 4'd14, LEAD, LEAD, 4'd9);

        // Reset asserted in the 4th conversion cycle of -45.
        @(negedge clk);
        while (bus.in_ready !== 1'b1) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_num   = 8'hD3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_done", bus.done, 0);
        check("abort_an", bus.an, 4'b1110);
        check("abort_seg", bus.seg_code, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check_disp("abort", 4'd14, LEAD, LEAD, 4'd0);

        send(8'hD3, lat, rdy_k, dcnt);
        check("m45_latency", lat, 9);
        check_disp("m45", 4'd15, LEAD, 4'd4, 4'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
